fetch_mem_arbiter: RTL and testbench

- Shares one single-port, multi-cycle instruction/data memory between instruction fetch (IF) and the MEM-stage data access.
- Generates the IF freeze and a whole-pipeline stall; the IF stage treats the granted word as its Instruction.
- A one-entry fetch buffer keeps a completed fetch if the pipeline stalls before IF can consume it.
- Sits between IF_Stage/MEM_Stage and the memory model; replaces the combinational instruction ROM.

---
 rtl/fetch_mem_arbiter_if.sv | 40 ++++
 rtl/fetch_mem_arbiter.sv | 136 +++++++++++++
 tb/tb_fetch_mem_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_mem_arbiter_if.sv
// Signal bundle between IF/MEM pipeline stages, the fetch/data arbiter and the
// single-port memory. The arbiter uses the slave modport; the environment uses master.
interface fetch_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Pipeline side
    logic              flush;
    logic [ADDR_W-1:0] if_pc;
    logic              if_freeze;
    logic [DATA_W-1:0] if_inst;
    logic              mem_rd_en;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_stall;

    // Memory side: strobes are held until the single-cycle sram_ready pulse
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic              sram_rd;
    logic              sram_wr;
    logic [DATA_W-1:0] sram_rdata;
    logic              sram_ready;

    modport slave (
        input  flush, if_pc, mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
        input  sram_rdata, sram_ready,
        output if_freeze, if_inst, mem_rdata, mem_stall,
        output sram_addr, sram_wdata, sram_rd, sram_wr
    );

    modport master (
        output flush, if_pc, mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
        output sram_rdata, sram_ready,
        input  if_freeze, if_inst, mem_rdata, mem_stall,
        input  sram_addr, sram_wdata, sram_rd, sram_wr
    );
endinterface

// File: rtl/fetch_mem_arbiter.sv
// Arbitrates one multi-cycle single-port memory between instruction fetch and MEM-stage
// loads/stores, with a one-entry fetch buffer. Optional macro ARB_FAIRNESS_EN adds IF anti-starvation.
module fetch_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
`ifdef ARB_FAIRNESS_EN
    ,
    parameter int STARVE_MAX = 4
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_mem_arbiter_if.slave   bus,
    output logic [1:0]           o_dbg_state
);
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_IF_ACC   = 2'd1;
    localparam logic [1:0] S_MEM_ACC  = 2'd2;
    localparam logic [1:0] S_MEM_DONE = 2'd3;

    logic [1:0]        r_state;
    logic              r_buf_valid;
    logic              r_discard;
    logic              r_sram_rd;
    logic              r_sram_wr;
    logic [ADDR_W-1:0] r_sram_addr;
    logic [DATA_W-1:0] r_sram_wdata;
    logic [DATA_W-1:0] r_buf;
    logic [DATA_W-1:0] r_mem_rdata;

    logic w_mem_req;
    logic w_mem_stall;
    logic w_grant_mem;
    logic w_grant_if;

    assign w_mem_req   = bus.mem_rd_en | bus.mem_wr_en;
    assign w_mem_stall = w_mem_req & (r_state != S_MEM_DONE);

`ifdef ARB_FAIRNESS_EN
    logic [2:0] r_starve;
    logic       w_force_if;

    // Once MEM has won STARVE_MAX times in a row over a waiting fetch, let IF go first.
    assign w_force_if  = (r_starve == 3'(STARVE_MAX)) & ~r_buf_valid & ~bus.flush;
    assign w_grant_mem = w_mem_req & ~w_force_if;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= 3'd0;
        end else if (r_state == S_IDLE) begin
            if (w_grant_mem && !r_buf_valid && r_starve != 3'd7)
                r_starve <= r_starve + 3'd1;
            else if (w_grant_if)
                r_starve <= 3'd0;
        end
    end
`else
    assign w_grant_mem = w_mem_req;
`endif

    assign w_grant_if = ~w_grant_mem & ~r_buf_valid & ~bus.flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_buf_valid  <= 1'b0;
            r_discard    <= 1'b0;
            r_sram_rd    <= 1'b0;
            r_sram_wr    <= 1'b0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
            r_buf        <= '0;
            r_mem_rdata  <= '0;
        end else begin
            if (r_buf_valid && !w_mem_stall)
                r_buf_valid <= 1'b0;
            // A flush during a fetch marks the in-flight word as stale.
            if (bus.flush) begin
                r_buf_valid <= 1'b0;
                if (r_state == S_IF_ACC)
                    r_discard <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_grant_mem) begin
                        r_state      <= S_MEM_ACC;
                        r_sram_addr  <= bus.mem_addr;
                        r_sram_wdata <= bus.mem_wdata;
                        r_sram_rd    <= bus.mem_rd_en;
                        r_sram_wr    <= bus.mem_wr_en & ~bus.mem_rd_en;
                    end else if (w_grant_if) begin
                        r_state     <= S_IF_ACC;
                        r_sram_addr <= bus.if_pc;
                        r_sram_rd   <= 1'b1;
                        r_sram_wr   <= 1'b0;
                    end
                end
                S_IF_ACC: begin
                    if (bus.sram_ready) begin
                        r_sram_rd <= 1'b0;
                        r_sram_wr <= 1'b0;
                        if (!r_discard && !bus.flush) begin
                            r_buf       <= bus.sram_rdata;
                            r_buf_valid <= 1'b1;
                        end
                        r_discard <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                S_MEM_ACC: begin
                    if (bus.sram_ready) begin
                        r_sram_rd <= 1'b0;
                        r_sram_wr <= 1'b0;
                        if (r_sram_rd)
                            r_mem_rdata <= bus.sram_rdata;
                        r_state <= S_MEM_DONE;
                    end
                end
                S_MEM_DONE: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.if_freeze  = ~r_buf_valid;
    assign bus.if_inst    = r_buf;
    assign bus.mem_rdata  = r_mem_rdata;
    assign bus.mem_stall  = w_mem_stall;
    assign bus.sram_addr  = r_sram_addr;
    assign bus.sram_wdata = r_sram_wdata;
    assign bus.sram_rd    = r_sram_rd;
    assign bus.sram_wr    = r_sram_wr;
    assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Bench for fetch_mem_arbiter: directed scenarios plus randomized fetch/load/store/flush
// episodes checked against a word-array memory model and an expected-data queue.
module tb_fetch_mem_arbiter;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 512;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    fetch_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    fetch_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    int n_tests   = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int ready_cyc = -100;
    int mem_lat   = 0;
    bit rand_lat  = 1'b0;

    logic [DW-1:0] mem     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int widx(input logic [AW-1:0] a);
        return int'(a[10:2]);
    endfunction

    // ---------------- scoreboard check ----------------
    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_fetch(input string tag);
        int n = 0;
        while (bus.if_freeze && n < 60) begin
            step();
            n++;
        end
        if (bus.if_freeze) check_eq({tag, "_fetch_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic wait_mem_done(input string tag);
        int n = 0;
        while (bus.mem_stall && n < 60) begin
            step();
            n++;
        end
        if (bus.mem_stall) check_eq({tag, "_mem_timeout"}, 32'd1, 32'd0);
    endtask

    // Memory responder: pulses sram_ready after mem_lat (or random 0..3) extra strobe cycles.
    int wait_left = 0;
    bit busy      = 1'b0;
    initial begin
        bus.sram_ready = 1'b0;
        bus.sram_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.sram_ready = 1'b0;
            if (bus.sram_rd || bus.sram_wr) begin
                if (!busy) begin
                    busy      = 1'b1;
                    wait_left = rand_lat ? int'($urandom_range(0, 3)) : mem_lat;
                end
                if (wait_left == 0) begin
                    bus.sram_ready = 1'b1;
                    ready_cyc      = cyc;
                    busy           = 1'b0;
                    if (bus.sram_rd) begin
                        bus.sram_rdata = mem[widx(bus.sram_addr)];
                    end else begin
                        bus.sram_rdata = $urandom;
                        mem[widx(bus.sram_addr)] = bus.sram_wdata;
                    end
                end else begin
                    wait_left--;
                end
            end else begin
                busy = 1'b0;
            end
        end
    end

    // Read and write strobes must never be active together.
    always begin
        @(posedge clk);
        #3;
        if (!rst && (bus.sram_rd || bus.sram_wr))
            check_eq("one_strobe", 32'(bus.sram_rd & bus.sram_wr), 32'd0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int done;
        int if_at;
        int n;
        int exp_if_at;
        bit got_inst;
        bit leak;

        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = $urandom;
            mem[i]     = ref_mem[i];
        end
        ref_mem[widx(32'h10)] = 32'hE3A00014;
        mem[widx(32'h10)]     = 32'hE3A00014;

        // flush held high keeps the arbiter from fetching between scenarios
        bus.flush     = 1'b1;
        bus.if_pc     = '0;
        bus.mem_rd_en = 1'b0;
        bus.mem_wr_en = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        // T1: reset in the middle of a data access
        mem_lat = 8;
        bus.mem_rd_en = 1'b1;
        bus.mem_addr  = 32'h100;
        step();
        check_eq("t1_pre_rd", 32'(bus.sram_rd), 32'd1);
        rst = 1'b1;
        step();
        step();
        check_eq("t1_state", 32'(dbg_state), 32'd0);
        check_eq("t1_sram_rd", 32'(bus.sram_rd), 32'd0);
        check_eq("t1_sram_wr", 32'(bus.sram_wr), 32'd0);
        check_eq("t1_sram_addr", bus.sram_addr, 32'd0);
        check_eq("t1_if_freeze", 32'(bus.if_freeze), 32'd1);
        check_eq("t1_if_inst", bus.if_inst, 32'd0);
        check_eq("t1_mem_rdata", bus.mem_rdata, 32'd0);
        check_eq("t1_stall_req", 32'(bus.mem_stall), 32'd1);
        rst = 1'b0;
        bus.mem_rd_en = 1'b0;
        #1;
        check_eq("t1_stall_noreq", 32'(bus.mem_stall), 32'd0);
        step();

        // T2: plain fetch, ready two cycles after the strobe rises
        mem_lat = 2;
        bus.if_pc = 32'h10;
        bus.flush = 1'b0;
        step();
        check_eq("t2_sram_rd", 32'(bus.sram_rd), 32'd1);
        check_eq("t2_sram_addr", bus.sram_addr, 32'h10);
        wait_fetch("t2");
        check_eq("t2_latency", 32'(cyc), 32'(ready_cyc + 1));
        check_eq("t2_if_inst", bus.if_inst, 32'hE3A00014);
        bus.flush = 1'b1;
        step();

        // T3: load and fetch requested together; load goes first
        mem_lat = 1;
        bus.if_pc     = 32'h30;
        bus.mem_addr  = 32'h400;
        bus.mem_rd_en = 1'b1;
        bus.flush     = 1'b0;
        step();
        check_eq("t3_sram_rd", 32'(bus.sram_rd), 32'd1);
        check_eq("t3_sram_addr", bus.sram_addr, 32'h400);
        check_eq("t3_stall", 32'(bus.mem_stall), 32'd1);
        wait_mem_done("t3");
        check_eq("t3_latency", 32'(cyc), 32'(ready_cyc + 1));
        check_eq("t3_mem_rdata", bus.mem_rdata, ref_mem[widx(32'h400)]);
        check_eq("t3_no_fetch_yet", 32'(bus.if_freeze), 32'd1);
        bus.mem_rd_en = 1'b0;
        step();
        check_eq("t3_idle_rd", 32'(bus.sram_rd), 32'd0);
        step();
        check_eq("t3_fetch_rd", 32'(bus.sram_rd), 32'd1);
        check_eq("t3_fetch_addr", bus.sram_addr, 32'h30);
        wait_fetch("t3");
        check_eq("t3_if_inst", bus.if_inst, ref_mem[widx(32'h30)]);
        bus.flush = 1'b1;
        step();

        // T4: flush while a fetch is in flight
        mem_lat = 3;
        bus.if_pc = 32'h20;
        bus.flush = 1'b0;
        step();
        check_eq("t4_first_addr", bus.sram_addr, 32'h20);
        step();
        bus.flush = 1'b1;
        bus.if_pc = 32'h80;
        step();
        bus.flush = 1'b0;
        leak = 1'b0;
        n = 0;
        while (bus.sram_rd && n < 60) begin
            if (!bus.if_freeze) leak = 1'b1;
            step();
            n++;
        end
        while (!bus.sram_rd && n < 60) begin
            if (!bus.if_freeze) leak = 1'b1;
            step();
            n++;
        end
        check_eq("t4_refetch_rd", 32'(bus.sram_rd), 32'd1);
        check_eq("t4_refetch_addr", bus.sram_addr, 32'h80);
        check_eq("t4_no_leak", 32'(leak), 32'd0);
        wait_fetch("t4");
        check_eq("t4_if_inst", bus.if_inst, ref_mem[widx(32'h80)]);
        bus.flush = 1'b1;
        step();

        // T5: store arrives while a fetched word waits in the buffer
        mem_lat = 1;
        bus.if_pc = 32'h40;
        bus.flush = 1'b0;
        wait_fetch("t5");
        bus.mem_wr_en = 1'b1;
        bus.mem_addr  = 32'h404;
        bus.mem_wdata = 32'hAA;
        ref_mem[widx(32'h404)] = 32'hAA;
        step();
        check_eq("t5_sram_wr", 32'(bus.sram_wr), 32'd1);
        check_eq("t5_sram_wdata", bus.sram_wdata, 32'hAA);
        check_eq("t5_sram_addr", bus.sram_addr, 32'h404);
        check_eq("t5_buf_kept", 32'(bus.if_freeze), 32'd0);
        wait_mem_done("t5");
        check_eq("t5_done_freeze", 32'(bus.if_freeze), 32'd0);
        check_eq("t5_done_inst", bus.if_inst, ref_mem[widx(32'h40)]);
        bus.mem_wr_en = 1'b0;
        bus.if_pc     = 32'h404;
        step();
        wait_fetch("t5b");
        check_eq("t5_store_visible", bus.if_inst, 32'hAA);
        bus.flush = 1'b1;
        step();

        // T6: six back-to-back loads with a fetch waiting
        mem_lat = 0;
        bus.if_pc     = 32'h50;
        bus.mem_addr  = 32'h200;
        bus.mem_rd_en = 1'b1;
        bus.flush     = 1'b0;
        done     = 0;
        if_at    = -1;
        got_inst = 1'b0;
        n        = 0;
        while ((done < 6 || if_at < 0 || !got_inst) && n < 300) begin
            step();
            n++;
            if (bus.sram_rd && bus.sram_addr == 32'h50 && if_at < 0) if_at = done;
            if (!bus.if_freeze && !got_inst) begin
                check_eq("t6_if_inst", bus.if_inst, ref_mem[widx(32'h50)]);
                got_inst = 1'b1;
            end
            if (bus.mem_rd_en && !bus.mem_stall) begin
                check_eq("t6_rdata", bus.mem_rdata, ref_mem[widx(bus.mem_addr)]);
                done++;
                if (done == 6) bus.mem_rd_en = 1'b0;
                else bus.mem_addr = 32'h200 + 32'(4 * done);
            end
        end
`ifdef ARB_FAIRNESS_EN
        exp_if_at = 4;
`else
        exp_if_at = 6;
`endif
        check_eq("t6_loads_done", 32'(done), 32'd6);
        check_eq("t6_if_grant_after", 32'(if_at), 32'(exp_if_at));
        bus.flush = 1'b1;
        step();
        step();

        // Randomized episodes: optional load/store and optional flush around one fetch
        rand_lat = 1'b1;
        for (int e = 0; e < 40; e++) begin
            int op;
            int k;
            bit fin;
            bit flushed;
            logic [AW-1:0] pc;
            logic [AW-1:0] pc2;
            logic [AW-1:0] ma;
            logic [DW-1:0] wd;
            step();
            op  = int'($urandom_range(0, 3));
            pc  = 32'($urandom_range(0, 63)) << 2;
            ma  = 32'($urandom_range(0, 63)) << 2;
            if ($urandom_range(0, 1) == 1) ma = pc;
            wd  = $urandom;
            k   = int'($urandom_range(1, 20));
            pc2 = (pc + 32'(4 * k)) & 32'hFC;
            if (op == 1) begin
                exp_q.push_back(ref_mem[widx(ma)]);
                bus.mem_rd_en = 1'b1;
            end else if (op == 2) begin
                ref_mem[widx(ma)] = wd;
                bus.mem_wr_en = 1'b1;
            end
            exp_q.push_back(ref_mem[widx(op == 3 ? pc2 : pc)]);
            bus.mem_addr  = ma;
            bus.mem_wdata = wd;
            bus.if_pc     = pc;
            bus.flush     = 1'b0;
            fin     = 1'b0;
            flushed = 1'b0;
            n       = 0;
            while (!fin && n < 100) begin
                step();
                n++;
                if (bus.flush) bus.flush = 1'b0;
                if (bus.sram_wr) begin
                    check_eq("rnd_wr_addr", bus.sram_addr, ma);
                    check_eq("rnd_wr_data", bus.sram_wdata, wd);
                end
                if ((bus.mem_rd_en || bus.mem_wr_en) && !bus.mem_stall) begin
                    check_eq("rnd_mem_latency", 32'(cyc), 32'(ready_cyc + 1));
                    check_eq("rnd_mem_first", 32'(bus.if_freeze), 32'd1);
                    if (bus.mem_rd_en) check_eq("rnd_load", bus.mem_rdata, exp_q.pop_front());
                    bus.mem_rd_en = 1'b0;
                    bus.mem_wr_en = 1'b0;
                end else if (!bus.if_freeze && !bus.mem_stall) begin
                    check_eq("rnd_fetch_latency", 32'(cyc), 32'(ready_cyc + 1));
                    check_eq("rnd_fetch", bus.if_inst, exp_q.pop_front());
                    bus.flush = 1'b1;
                    fin = 1'b1;
                end else if (op == 3 && !flushed && bus.sram_rd && !bus.mem_rd_en && !bus.mem_wr_en) begin
                    bus.flush = 1'b1;
                    bus.if_pc = pc2;
                    flushed = 1'b1;
                end
            end
            if (!fin) begin
                check_eq("rnd_timeout", 32'd1, 32'd0);
                exp_q.delete();
                bus.mem_rd_en = 1'b0;
                bus.mem_wr_en = 1'b0;
                bus.flush     = 1'b1;
            end
        end
        step();
        check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);

        // ---------------- report ----------------
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
